// File: rtl/mem_bus_router_if.sv
// rtl/mem_bus_router_if.sv - CPU-side request/response bus of the memory router
// master = pipeline memory stage, slave = router.
interface mem_bus_router_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_bus_router.sv
// rtl/mem_bus_router.sv - address-decoding memory-bus router with per-access timeout
// Top address bits pick RAM (0) or a peripheral; errors are flagged and counted.
module mem_bus_router #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                SEL_BITS    = 3,
  parameter int                NUM_TARGETS = 8,
  parameter int                TIMEOUT     = 15,
  parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEADBEEF
) (
  input  logic                          clk,
  input  logic                          reset,
  mem_bus_router_if.slave               cpu,
  output logic [NUM_TARGETS-1:0]        tgt_sel,
  output logic                          tgt_write,
  output logic [ADDR_W-SEL_BITS-1:0]    tgt_addr,
  output logic [DATA_W-1:0]             tgt_wdata,
  input  logic [NUM_TARGETS*DATA_W-1:0] tgt_rdata,
  input  logic [NUM_TARGETS-1:0]        tgt_ack,
  output logic [7:0]                    err_count
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  wait_cnt;
  logic [SEL_BITS-1:0] req_idx;
  logic              ack_hit;
  logic [DATA_W-1:0] sel_rdata;
  logic [7:0]        err_next;

  assign req_idx       = cpu.req_addr[ADDR_W-1 -: SEL_BITS];
  assign cpu.req_ready = (state == IDLE);
  // tgt_sel is the one-hot of the latched index, so masking with it ignores foreign acks
  assign ack_hit       = |(tgt_ack & tgt_sel);
  assign err_next      = (err_count == 8'hFF) ? err_count : err_count + 8'd1;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (tgt_sel[i]) sel_rdata = tgt_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      tgt_sel        <= '0;
      tgt_write      <= 1'b0;
      tgt_addr       <= '0;
      tgt_wdata      <= '0;
      cpu.resp_valid <= 1'b0;
      cpu.resp_rdata <= '0;
      cpu.resp_err   <= 1'b0;
      err_count      <= '0;
    end else begin
      cpu.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu.req_valid) begin
            tgt_write <= cpu.req_write;
            tgt_addr  <= cpu.req_addr[ADDR_W-SEL_BITS-1:0];
            tgt_wdata <= cpu.req_wdata;
            if (int'(req_idx) >= NUM_TARGETS) begin
              state          <= RESP;
              cpu.resp_valid <= 1'b1;
              cpu.resp_err   <= 1'b1;
              cpu.resp_rdata <= ERR_DATA;
              err_count      <= err_next;
            end else begin
              state    <= ACCESS;
              tgt_sel  <= NUM_TARGETS'(1) << req_idx;
              wait_cnt <= '0;
            end
          end
        end
        ACCESS: begin
          // ack takes priority over a timeout firing on the same edge
          if (ack_hit) begin
            state          <= RESP;
            tgt_sel        <= '0;
            cpu.resp_valid <= 1'b1;
            cpu.resp_err   <= 1'b0;
            cpu.resp_rdata <= tgt_write ? '0 : sel_rdata;
          end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            state          <= RESP;
            tgt_sel        <= '0;
            cpu.resp_valid <= 1'b1;
            cpu.resp_err   <= 1'b1;
            cpu.resp_rdata <= ERR_DATA;
            err_count      <= err_next;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        RESP: begin
          state          <= IDLE;
          cpu.resp_err   <= 1'b0;
          cpu.resp_rdata <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_bus_router.sv
// tb/tb_mem_bus_router.sv - directed self-checking bench for mem_bus_router
// dut1 uses 8 targets, dut2 uses 2 targets to reach unmapped indices.
module tb_mem_bus_router;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  mem_bus_router_if #(.DATA_W(32), .ADDR_W(32)) b1 ();
  mem_bus_router_if #(.DATA_W(32), .ADDR_W(32)) b2 ();

  logic [7:0]   sel1, ack1, ec1;
  logic         wr1;
  logic [28:0]  addr1;
  logic [31:0]  wd1;
  logic [255:0] rd1;

  logic [1:0]   sel2, ack2;
  logic [7:0]   ec2;
  logic         wr2;
  logic [28:0]  addr2;
  logic [31:0]  wd2;
  logic [63:0]  rd2;

  mem_bus_router dut1 (
    .clk(clk), .reset(reset), .cpu(b1),
    .tgt_sel(sel1), .tgt_write(wr1), .tgt_addr(addr1), .tgt_wdata(wd1),
    .tgt_rdata(rd1), .tgt_ack(ack1), .err_count(ec1)
  );

  mem_bus_router #(.NUM_TARGETS(2)) dut2 (
    .clk(clk), .reset(reset), .cpu(b2),
    .tgt_sel(sel2), .tgt_write(wr2), .tgt_addr(addr2), .tgt_wdata(wd2),
    .tgt_rdata(rd2), .tgt_ack(ack2), .err_count(ec2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start1(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    b1.req_write = wr;
    b1.req_addr  = addr;
    b1.req_wdata = wdata;
    b1.req_valid = 1'b1;
    n_cmp++; if (b1.req_ready !== 1'b1) begin n_bad++; $display("FAIL start_ready: got %b want 1", b1.req_ready); end
    tick;
    b1.req_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    n_cmp++; if (b1.req_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_ready: got %b want 1", b1.req_ready); end
    n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rst_resp_valid: got %b want 0", b1.resp_valid); end
    n_cmp++; if (sel1 !== 8'h00)         begin n_bad++; $display("FAIL rst_sel: got %h want 00", sel1); end
    n_cmp++; if (ec1 !== 8'h00)          begin n_bad++; $display("FAIL rst_err_count: got %0d want 0", ec1); end
    n_cmp++; if (b1.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", b1.resp_rdata); end
    tick;
    n_cmp++; if (b1.req_ready !== 1'b1)  begin n_bad++; $display("FAIL rst_ready2: got %b want 1", b1.req_ready); end
  endtask

  task automatic test_read_ram;
    rd1[31:0] = 32'h1234_5678;
    start1(1'b0, 32'h0000_0010, 32'h0);
    n_cmp++; if (sel1 !== 8'h01)         begin n_bad++; $display("FAIL rd_sel: got %h want 01", sel1); end
    n_cmp++; if (addr1 !== 29'h10)       begin n_bad++; $display("FAIL rd_addr: got %h want 10", addr1); end
    n_cmp++; if (b1.req_ready !== 1'b0)  begin n_bad++; $display("FAIL rd_ready_busy: got %b want 0", b1.req_ready); end
    ack1 = 8'h01;
    tick;
    ack1 = 8'h00;
    n_cmp++; if (b1.resp_valid !== 1'b1) begin n_bad++; $display("FAIL rd_valid: got %b want 1", b1.resp_valid); end
    n_cmp++; if (b1.resp_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rd_data: got %h want 12345678", b1.resp_rdata); end
    n_cmp++; if (b1.resp_err !== 1'b0)   begin n_bad++; $display("FAIL rd_err: got %b want 0", b1.resp_err); end
    n_cmp++; if (sel1 !== 8'h00)         begin n_bad++; $display("FAIL rd_sel_drop: got %h want 00", sel1); end
    tick;
    n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rd_valid_once: got %b want 0", b1.resp_valid); end
    n_cmp++; if (b1.req_ready !== 1'b1)  begin n_bad++; $display("FAIL rd_ready_c3: got %b want 1", b1.req_ready); end
  endtask

  task automatic test_back_to_back;
    rd1[127:96]  = 32'hCAFE_0003;
    rd1[159:128] = 32'h0000_0044;
    start1(1'b0, 32'h6000_0008, 32'h0);
    ack1 = 8'h08;
    b1.req_write = 1'b0;
    b1.req_addr  = 32'h8000_000C;
    b1.req_valid = 1'b1;
    tick;
    ack1 = 8'h00;
    n_cmp++; if (b1.resp_rdata !== 32'hCAFE_0003) begin n_bad++; $display("FAIL b2b_data1: got %h want cafe0003", b1.resp_rdata); end
    n_cmp++; if (b1.req_ready !== 1'b0)  begin n_bad++; $display("FAIL b2b_ready_c2: got %b want 0", b1.req_ready); end
    tick;
    n_cmp++; if (sel1 !== 8'h00)         begin n_bad++; $display("FAIL b2b_no_early_accept: got %h want 00", sel1); end
    n_cmp++; if (b1.req_ready !== 1'b1)  begin n_bad++; $display("FAIL b2b_ready_c3: got %b want 1", b1.req_ready); end
    tick;
    b1.req_valid = 1'b0;
    n_cmp++; if (sel1 !== 8'h10)         begin n_bad++; $display("FAIL b2b_sel2: got %h want 10", sel1); end
    n_cmp++; if (addr1 !== 29'hC)        begin n_bad++; $display("FAIL b2b_addr2: got %h want c", addr1); end
    ack1 = 8'h10;
    tick;
    ack1 = 8'h00;
    n_cmp++; if (b1.resp_rdata !== 32'h44) begin n_bad++; $display("FAIL b2b_data2: got %h want 44", b1.resp_rdata); end
    tick;
  endtask

  task automatic test_write_periph;
    rd1[63:32] = 32'hFFFF_FFFF;
    start1(1'b1, 32'h2000_0004, 32'h0000_00A5);
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (sel1 !== 8'b0000_0010) begin n_bad++; $display("FAIL wr_sel c%0d: got %b want 00000010", c, sel1); end
      n_cmp++; if (addr1 !== 29'h4)      begin n_bad++; $display("FAIL wr_addr c%0d: got %h want 4", c, addr1); end
      n_cmp++; if (wd1 !== 32'hA5)       begin n_bad++; $display("FAIL wr_wdata c%0d: got %h want a5", c, wd1); end
      n_cmp++; if (wr1 !== 1'b1)         begin n_bad++; $display("FAIL wr_write c%0d: got %b want 1", c, wr1); end
      n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL wr_early_resp c%0d: got %b want 0", c, b1.resp_valid); end
      if (c == 4) ack1 = 8'h02;
      tick;
    end
    ack1 = 8'h00;
    n_cmp++; if (b1.resp_valid !== 1'b1) begin n_bad++; $display("FAIL wr_valid: got %b want 1", b1.resp_valid); end
    n_cmp++; if (b1.resp_rdata !== 32'h0) begin n_bad++; $display("FAIL wr_rdata: got %h want 0", b1.resp_rdata); end
    n_cmp++; if (b1.resp_err !== 1'b0)   begin n_bad++; $display("FAIL wr_err: got %b want 0", b1.resp_err); end
    tick;
  endtask

  task automatic test_timeout;
    int lat;
    bit found;
    lat = 0;
    found = 1'b0;
    start1(1'b0, 32'h4000_0000, 32'h0);
    for (int c = 1; c <= 40 && !found; c++) begin
      if (b1.resp_valid === 1'b1) begin found = 1'b1; lat = c; end
      else tick;
    end
    n_cmp++; if (!found)                 begin n_bad++; $display("FAIL to_seen: got none want resp_valid"); end
    n_cmp++; if (lat !== 16)             begin n_bad++; $display("FAIL to_latency: got %0d want 16", lat); end
    n_cmp++; if (b1.resp_err !== 1'b1)   begin n_bad++; $display("FAIL to_err: got %b want 1", b1.resp_err); end
    n_cmp++; if (b1.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL to_rdata: got %h want deadbeef", b1.resp_rdata); end
    n_cmp++; if (ec1 !== 8'd1)           begin n_bad++; $display("FAIL to_err_count: got %0d want 1", ec1); end
    n_cmp++; if (sel1 !== 8'h00)         begin n_bad++; $display("FAIL to_sel_drop: got %h want 00", sel1); end
    tick;
  endtask

  task automatic test_unmapped;
    b2.req_write = 1'b0;
    b2.req_addr  = 32'hE000_0000;
    b2.req_wdata = 32'h0;
    b2.req_valid = 1'b1;
    n_cmp++; if (b2.req_ready !== 1'b1)  begin n_bad++; $display("FAIL um_ready: got %b want 1", b2.req_ready); end
    tick;
    b2.req_valid = 1'b0;
    n_cmp++; if (b2.resp_valid !== 1'b1) begin n_bad++; $display("FAIL um_valid: got %b want 1", b2.resp_valid); end
    n_cmp++; if (b2.resp_err !== 1'b1)   begin n_bad++; $display("FAIL um_err: got %b want 1", b2.resp_err); end
    n_cmp++; if (b2.resp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL um_rdata: got %h want deadbeef", b2.resp_rdata); end
    n_cmp++; if (sel2 !== 2'b00)         begin n_bad++; $display("FAIL um_sel: got %b want 00", sel2); end
    n_cmp++; if (ec2 !== 8'd1)           begin n_bad++; $display("FAIL um_err_count: got %0d want 1", ec2); end
    tick;
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_bad++; $display("FAIL um_valid_once: got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.req_ready !== 1'b1)  begin n_bad++; $display("FAIL um_ready_after: got %b want 1", b2.req_ready); end
  endtask

  task automatic test_wrong_ack;
    rd1[31:0]   = 32'h0BAD_F00D;
    rd1[127:96] = 32'h3333_3333;
    start1(1'b0, 32'h0000_0100, 32'h0);
    for (int c = 1; c <= 15; c++) begin
      n_cmp++; if (sel1 !== 8'h01)         begin n_bad++; $display("FAIL wa_sel c%0d: got %h want 01", c, sel1); end
      n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL wa_early_resp c%0d: got %b want 0", c, b1.resp_valid); end
      ack1 = (c == 15) ? 8'h01 : 8'h08;
      tick;
    end
    ack1 = 8'h00;
    n_cmp++; if (b1.resp_valid !== 1'b1) begin n_bad++; $display("FAIL wa_valid: got %b want 1", b1.resp_valid); end
    n_cmp++; if (b1.resp_err !== 1'b0)   begin n_bad++; $display("FAIL wa_err: got %b want 0", b1.resp_err); end
    n_cmp++; if (b1.resp_rdata !== 32'h0BAD_F00D) begin n_bad++; $display("FAIL wa_rdata: got %h want 0badf00d", b1.resp_rdata); end
    n_cmp++; if (ec1 !== 8'd1)           begin n_bad++; $display("FAIL wa_err_count: got %0d want 1", ec1); end
    tick;
  endtask

  task automatic test_reset_mid;
    start1(1'b0, 32'h0000_0020, 32'h0);
    tick;
    reset = 1'b1;
    tick;
    n_cmp++; if (sel1 !== 8'h00)         begin n_bad++; $display("FAIL rm_sel: got %h want 00", sel1); end
    n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", b1.resp_valid); end
    n_cmp++; if (ec1 !== 8'd0)           begin n_bad++; $display("FAIL rm_err_count: got %0d want 0", ec1); end
    reset = 1'b0;
    tick;
    n_cmp++; if (b1.req_ready !== 1'b1)  begin n_bad++; $display("FAIL rm_ready: got %b want 1", b1.req_ready); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (b1.resp_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stray_resp c%0d: got %b want 0", c, b1.resp_valid); end
      tick;
    end
  endtask

  task automatic test_saturate;
    bit seen;
    for (int n = 0; n < 300; n++) begin
      start1(1'b0, 32'hA000_0000, 32'h0);
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        if (b1.resp_valid === 1'b1) seen = 1'b1;
        else tick;
      end
      if (!seen) begin
        n_cmp++; n_bad++;
        $display("FAIL sat_resp n%0d: got none want resp_valid", n);
      end
      if (n == 254) begin
        n_cmp++; if (ec1 !== 8'd255) begin n_bad++; $display("FAIL sat_reach: got %0d want 255", ec1); end
      end
      tick;
    end
    n_cmp++; if (ec1 !== 8'd255)         begin n_bad++; $display("FAIL sat_hold: got %0d want 255", ec1); end
  endtask

  initial begin
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0; b2.req_wdata = '0;
    ack1 = '0; rd1 = '0;
    ack2 = '0; rd2 = '0;
    test_reset;
    test_read_ram;
    test_back_to_back;
    test_write_periph;
    test_timeout;
    test_unmapped;
    test_wrong_ack;
    test_reset_mid;
    test_saturate;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
